mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning request write-data and read-data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning request address width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of request queue entries (power of two, at least 2).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk (input, 1) is the sole clock, and rst_n (input, 1) is the active-low async reset.
REQ-005 SHALL have port m0_valid, input, 1 bit, meaning requester 0 presents a request.
REQ-006 SHALL have port m0_ready, output, 1 bit, meaning requester 0's request is accepted this cycle.
REQ-007 SHALL have port m0_wr, input, 1 bit, meaning requester 0's direction (1=write, 0=read).
REQ-008 SHALL have port m0_addr, input, ADDR_WIDTH bits, meaning requester 0's address.
REQ-009 SHALL have port m0_wdata, input, DATA_WIDTH bits, meaning requester 0's write data.
REQ-010 SHALL have ports m1_valid, m1_ready, m1_wr, m1_addr and m1_wdata with the same directions, widths and meanings for requester 1.
REQ-011 SHALL have port mem_ready, input, 1 bit, meaning the downstream memory controller consumes the presented request.
REQ-012 SHALL have port rd_wr_valid, output, 1 bit, meaning a request is presented to the memory controller.
REQ-013 SHALL have port rd_wr_mem, output, 1 bit, meaning the presented request's direction (1=write, 0=read).
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH bits, meaning the presented request's address.
REQ-015 SHALL have port wr_data, output, DATA_WIDTH bits, meaning the presented request's write data.
REQ-016 SHALL have port req_count, output, $clog2(FIFO_DEPTH)+1 bits, meaning the current queue occupancy.

Function
REQ-017 SHALL enqueue at most one request per cycle, with enqueue occurring on a rising clk edge where mX_valid and mX_ready are both 1.
REQ-018 SHALL compute mX_ready combinationally, and SHALL drive at most one mX_ready high in any cycle.
REQ-019 SHALL drive m0_ready and m1_ready both to 0 whenever req_count equals FIFO_DEPTH, regardless of mem_ready in that cycle (no same-cycle pass-through when full).
REQ-020 SHALL, when not full and exactly one requester is valid, grant that requester.
REQ-021 SHALL, when not full and both requesters are valid, grant the requester indicated by a 1-bit round-robin pointer rr_ptr (0 = m0).
REQ-022 SHALL update rr_ptr only on an accepted request, setting it to the index of the non-granted requester.
REQ-023 SHALL leave rr_ptr unchanged on cycles with no acceptance.
REQ-024 SHALL store {wr, addr, wdata} of an accepted request in the queue entry at the write pointer.
REQ-025 SHALL implement the queue's read and write pointers modulo FIFO_DEPTH, wrapping from FIFO_DEPTH-1 to 0.
REQ-026 SHALL drive rd_wr_valid as (req_count != 0), with rd_wr_mem, mem_addr and wr_data driven directly from the head entry (first-word fall-through).
REQ-027 SHALL give an enqueue into an empty queue a latency of one cycle: the request appears on the outputs in the cycle after acceptance.
REQ-028 SHALL dequeue the head entry on a rising clk edge where rd_wr_valid and mem_ready are both 1.
REQ-029 SHALL ignore mem_ready while rd_wr_valid is 0.
REQ-030 SHALL, on a simultaneous enqueue and dequeue, keep req_count unchanged while advancing both pointers.
REQ-031 SHALL otherwise change req_count by +1 on an enqueue and by -1 on a dequeue.
REQ-032 SHALL hold the head entry's output values stable while rd_wr_valid is 1 and mem_ready is 0.
REQ-033 SHALL deliver requests to the memory controller in strict acceptance order.

Reset
REQ-034 SHALL, while rst_n is 0, clear req_count, the read pointer, the write pointer and rr_ptr to 0, and clear all queue entries to 0.
REQ-035 SHALL drive rd_wr_valid, rd_wr_mem, mem_addr, wr_data, m0_ready and m1_ready to 0 during reset.
REQ-036 SHALL, on a reset asserted mid-operation, discard all queued requests immediately (asynchronously), with no request presented after reset release until a new one is accepted.

Verification
REQ-037 SHALL include a single-request test: m0 write, addr 0x0010, wdata 0xDEADBEEF, accepted in cycle N -> in cycle N+1, rd_wr_valid=1, rd_wr_mem=1, mem_addr=0x0010 and wr_data=0xDEADBEEF; with mem_ready=1 in N+1, rd_wr_valid=0 in N+2.
REQ-038 SHALL include a round-robin test: m0 and m1 continuously valid after reset with mem_ready=1 -> grants alternate m0, m1, m0, m1.
REQ-039 SHALL include a full-queue test: mem_ready=0 with 4 accepted requests -> req_count=4 and m0_ready=m1_ready=0; asserting mem_ready=1 for one cycle -> req_count=3, then one further acceptance is possible.
REQ-040 SHALL include a simultaneous-event test: req_count=2, with one acceptance and mem_ready=1 in the same cycle -> req_count stays 2 and the output advances to the next entry in order.
REQ-041 SHALL include a wrap-around test: 9 requests with addresses 0x0001 through 0x0009 streamed through a depth-4 queue -> all 9 emerge in order with correct addresses.
REQ-042 SHALL include a mid-operation reset test: rst_n pulsed low with req_count=3 -> req_count=0, rd_wr_valid=0 and rr_ptr=0 immediately, and the first request after reset is granted to m0 when both requesters are valid.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter feeding a first-word-fall-through request queue
// that presents {wr, addr, wdata} to a downstream memory controller.
module mem_req_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          m0_valid,
  output logic                          m0_ready,
  input  logic                          m0_wr,
  input  logic [ADDR_WIDTH-1:0]         m0_addr,
  input  logic [DATA_WIDTH-1:0]         m0_wdata,
  input  logic                          m1_valid,
  output logic                          m1_ready,
  input  logic                          m1_wr,
  input  logic [ADDR_WIDTH-1:0]         m1_addr,
  input  logic [DATA_WIDTH-1:0]         m1_wdata,
  input  logic                          mem_ready,
  output logic                          rd_wr_valid,
  output logic                          rd_wr_mem,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   req_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = 1 + ADDR_WIDTH + DATA_WIDTH;

  logic [EntryW-1:0] entry_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              full, enq, deq, grant0, grant1;
  logic [EntryW-1:0] enq_entry;
  logic [EntryW-1:0] head;

  assign full = (count_q == CntW'(FIFO_DEPTH));

  // Grants are gated by rst_n so both readies read 0 while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !full) begin
      if (m0_valid && (!m1_valid || !rr_ptr_q)) begin
        grant0 = 1'b1;
      end else if (m1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign m0_ready  = grant0;
  assign m1_ready  = grant1;
  assign enq       = grant0 | grant1;
  assign deq       = (count_q != '0) && mem_ready;
  assign enq_entry = grant0 ? {m0_wr, m0_addr, m0_wdata} : {m1_wr, m1_addr, m1_wdata};

  always_comb begin
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (deq && !enq) begin
      count_d = count_q - 1'b1;
    end
    // Point at the requester that lost this acceptance.
    if (enq) begin
      rr_ptr_d = grant0;
    end
  end

  // Depth is a power of two, so PtrW-bit pointers wrap from FIFO_DEPTH-1 to 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rr_ptr_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      if (enq) begin
        entry_q[wptr_q] <= enq_entry;
        wptr_q          <= wptr_q + 1'b1;
      end
      if (deq) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  assign head        = entry_q[rptr_q];
  assign rd_wr_valid = (count_q != '0);
  assign rd_wr_mem   = head[EntryW-1];
  assign mem_addr    = head[DATA_WIDTH +: ADDR_WIDTH];
  assign wr_data     = head[DATA_WIDTH-1:0];
  assign req_count   = count_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: single request, round robin, full queue,
// simultaneous enqueue/dequeue, pointer wrap and mid-operation reset.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_valid = 1'b0, m0_wr = 1'b0;
  logic [15:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_valid = 1'b0, m1_wr = 1'b0;
  logic [15:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        mem_ready = 1'b0;
  logic        m0_ready, m1_ready, rd_wr_valid, rd_wr_mem;
  logic [15:0] mem_addr;
  logic [31:0] wr_data;
  logic [2:0]  req_count;

  int total = 0;
  int bad = 0;

  mem_req_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_valid    (m0_valid),
    .m0_ready    (m0_ready),
    .m0_wr       (m0_wr),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m1_valid    (m1_valid),
    .m1_ready    (m1_ready),
    .m1_wr       (m1_wr),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .mem_ready   (mem_ready),
    .rd_wr_valid (rd_wr_valid),
    .rd_wr_mem   (rd_wr_mem),
    .mem_addr    (mem_addr),
    .wr_data     (wr_data),
    .req_count   (req_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid  = 1'b0;
    m1_valid  = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int next_in, exp_out;
  logic took;

  initial begin
    // Reset state, with a requester valid to show ready is held low.
    m0_valid = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_valid", rd_wr_valid, 0);
    chk("rst_count", req_count, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", wr_data, 0);
    chk("rst_wr", rd_wr_mem, 0);
    do_reset();

    // Single request, one-cycle latency.
    m0_valid = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0010; m0_wdata = 32'hDEADBEEF;
    #1;
    chk("single_ready", m0_ready, 1);
    tick();
    m0_valid = 1'b0; mem_ready = 1'b1;
    #1;
    chk("single_valid", rd_wr_valid, 1);
    chk("single_wr", rd_wr_mem, 1);
    chk("single_addr", mem_addr, 16'h0010);
    chk("single_data", wr_data, 32'hDEADBEEF);
    chk("single_count", req_count, 1);
    tick();
    chk("single_drained", rd_wr_valid, 0);
    chk("single_count0", req_count, 0);

    // Round robin with both requesters always valid.
    do_reset();
    m0_valid = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0100;
    m1_valid = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0200;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_m0_ready", m0_ready, (i % 2 == 0));
      chk("rr_m1_ready", m1_ready, (i % 2 == 1));
      if (i > 0) chk("rr_addr", mem_addr, ((i - 1) % 2 == 0) ? 16'h0100 : 16'h0200);
      tick();
    end
    idle_inputs();

    // Full queue: no pass-through, one slot freed by a single dequeue.
    do_reset();
    m0_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m0_valid = 1'b1; m0_addr = 16'h0020 + 16'(i);
      tick();
    end
    m1_valid = 1'b1; m1_addr = 16'h0040; mem_ready = 1'b1;
    #1;
    chk("full_count", req_count, 4);
    chk("full_m0_ready", m0_ready, 0);
    chk("full_m1_ready", m1_ready, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("full_count3", req_count, 3);
    chk("full_m1_grant", m1_ready, 1);
    chk("full_m0_blocked", m0_ready, 0);
    tick();
    m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 1'b1;
    #1;
    chk("full_count4", req_count, 4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_order", mem_addr, (i < 3) ? 16'h0021 + 16'(i) : 16'h0040);
      tick();
    end
    chk("full_empty", rd_wr_valid, 0);
    mem_ready = 1'b0;

    // Simultaneous enqueue and dequeue.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      m0_valid = 1'b1; m0_addr = 16'h0031 + 16'(i);
      tick();
    end
    m0_addr = 16'h0033; mem_ready = 1'b1;
    #1;
    chk("sim_head", mem_addr, 16'h0031);
    tick();
    m0_valid = 1'b0;
    #1;
    chk("sim_count", req_count, 2);
    chk("sim_next", mem_addr, 16'h0032);
    tick();
    chk("sim_last", mem_addr, 16'h0033);
    tick();
    chk("sim_empty", rd_wr_valid, 0);

    // Wrap-around: 9 requests through the depth-4 queue.
    do_reset();
    next_in = 1;
    exp_out = 1;
    for (int cyc = 0; cyc < 60 && exp_out <= 9; cyc++) begin
      m0_valid  = (next_in <= 9);
      m0_addr   = 16'(next_in);
      mem_ready = (cyc >= 3);
      #1;
      took = m0_ready;
      if (rd_wr_valid && mem_ready) begin
        chk("wrap_addr", mem_addr, 16'(exp_out));
        exp_out++;
      end
      tick();
      if (took) next_in++;
    end
    chk("wrap_all_out", exp_out, 10);
    chk("wrap_empty", rd_wr_valid, 0);
    idle_inputs();

    // Mid-operation reset with three queued requests.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      m0_valid = 1'b1; m0_addr = 16'h0050 + 16'(i);
      tick();
    end
    m0_valid = 1'b0;
    #1;
    chk("mrst_pre_count", req_count, 3);
    rst_n = 1'b0;
    #1;
    chk("mrst_count", req_count, 0);
    chk("mrst_valid", rd_wr_valid, 0);
    chk("mrst_rr", dut.rr_ptr_q, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mrst_post_valid", rd_wr_valid, 0);
    m0_valid = 1'b1; m0_addr = 16'h0060;
    m1_valid = 1'b1; m1_addr = 16'h0070;
    #1;
    chk("mrst_m0_grant", m0_ready, 1);
    chk("mrst_m1_wait", m1_ready, 0);
    tick();
    idle_inputs();
    #1;
    chk("mrst_first_addr", mem_addr, 16'h0060);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
